register_file_nr_nw_latch: RTL and testbench
============================================

# register_file_nr_nw_latch

Latch-based standard-cell memory with NUM_RPORTS read ports and NUM_WPORTS write ports, byte enables and arbitrary (non-power-of-two) depth. It is the multi-port successor of the single-port latch register file for cluster-level scratch and register arrays. It adds deterministic write-collision resolution and a sequenced clear engine that zeroes the whole array after reset or on request. Storage is transparent-high latches clocked by per-word, per-byte `tc_clk_gating` cells behind one global write gate.

## Interface
- NUM_WORDS, 32: number of words; any value ≥2.
- DATA_WIDTH, 32: word width; multiple of 8.
- NUM_RPORTS, 2: read ports, ≥1.
- NUM_WPORTS, 2: write ports, ≥1.
- CLEAR_ON_RESET, 1: 1 = start a clear automatically when reset deasserts.
- ADDR_WIDTH, $clog2(NUM_WORDS): derived; do not override.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low; the only clock domain is clk
- clear_i  in  1  request a full-array zero clear; single-cycle pulse sampled when not busy
- busy_o  out  1  clear in progress; writes are dropped
- re_i  in  NUM_RPORTS  per-port read enable
- raddr_i  in  NUM_RPORTS×ADDR_WIDTH  read addresses
- rdata_o  out  NUM_RPORTS×DATA_WIDTH  read data
- we_i  in  NUM_WPORTS  per-port write enable
- waddr_i  in  NUM_WPORTS×ADDR_WIDTH  write addresses
- wdata_i  in  NUM_WPORTS×DATA_WIDTH  write data
- wbe_i  in  NUM_WPORTS×DATA_WIDTH/8  byte enables

## Operation
- Read: each port registers raddr_i on posedge clk when re_i is high and holds it otherwise. rdata_o is a combinational mux of the latch array at the registered address.
- A registered address ≥ NUM_WORDS drives rdata_o to 0.
- Write: each byte lane has a registered data value and a registered source-port index. For each word/byte the decoder asserts the gate enable when at least one port has we_i=1, wbe_i[b]=1 and waddr_i equal to that word.
- Collision: when several ports hit the same word/byte, the highest port index wins. The losing bytes are not written. Bytes from different ports in different lanes merge into the same word.
- A write address ≥ NUM_WORDS is ignored.
- Clear FSM states: IDLE, CLEAR.
  - Reset leads to CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - IDLE with clear_i leads to CLEAR and the pointer is set to 0.
  - In CLEAR, each cycle writes 0 to all bytes of word ptr, then increments ptr.
  - When ptr = NUM_WORDS-1, the FSM returns to IDLE.
  - clear_i during CLEAR is ignored; it does not restart the sequence.
- busy_o = (state == CLEAR). While busy, all we_i are dropped. Reads continue and may return partly cleared contents.
- Reset mid-clear aborts the sequence. Behaviour afterwards follows CLEAR_ON_RESET.
- Reset values:
  - read address registers 0; state per CLEAR_ON_RESET; ptr 0.
  - busy_o = CLEAR_ON_RESET.
  - Latch contents are not reset. rdata_o is undefined until the first clear or write completes.

## Timing
- Read latency: one cycle. An address presented in cycle N appears on rdata_o in cycle N+1.
- Write: data is sampled at the edge ending cycle N. Latches are transparent during the high phase of cycle N+1, and the value is stable from the falling edge of cycle N+1.
- Read-during-write to the same word in the same cycle N returns the new data in cycle N+1 (write-through through the open latch). Timing closes on the latch-to-rdata path in the low phase.
- Clear takes exactly NUM_WORDS cycles of busy_o=1.
  - After a clear_i pulse in cycle N: busy_o is high in cycles N+1 … N+NUM_WORDS.
  - Writes are accepted again in cycle N+NUM_WORDS+1.
- After rst_n deasserts with CLEAR_ON_RESET=1, busy_o is high for the first NUM_WORDS cycles.
- Gate enables are computed from registered-cycle inputs only. No combinational path runs from we_i to rdata_o.

## Structure
- Package register_file_latch_pkg holds:
  - the FSM state enum (IDLE, CLEAR);
  - the function for the byte-count constant;
  - the collision-priority helper (highest-index one-hot).
- Sub-module register_file_clear_ctrl holds the FSM, the pointer and busy_o. It outputs the per-word clear strobe that is merged into the write decoder.
- Clock gating uses the existing tc_clk_gating cell: one global gate plus NUM_WORDS×bytes per-lane gates, test_en_i tied 0.

## Test plan
- Reset with CLEAR_ON_RESET=1, NUM_WORDS=12 → busy_o high for 12 cycles; afterwards every address reads 0x00000000 on both ports.
- Port0 writes 0xDEADBEEF to addr 3 with wbe=4'b1111; port1 reads addr 3 in the following cycle → rdata_o[1]=0xDEADBEEF one cycle later.
- Same cycle: port0 writes 0x11111111 (wbe 1111) and port1 writes 0x22222222 (wbe 0011), both to addr 5 → word 5 reads 0x11112222.
- Write 0xA5A5A5A5 to addr 7 and read addr 7 in the same cycle → read returns 0xA5A5A5A5 in the next cycle (write-through).
- Pulse clear_i, then drive writes at cycle 2 of the clear and read at cycle NUM_WORDS+1 → all words 0 and the write is dropped; a write one cycle after busy_o falls persists.
- Read and write with address 12 on a 12-word array → rdata_o=0 and no word changes; assert rst_n low mid-clear → busy_o restarts the full sequence.

Source files
------------

// File: rtl/register_file_nr_nw_latch_pkg.sv
// register_file_latch_pkg: shared types and helpers for the latch register file
package register_file_latch_pkg;
  typedef enum logic {IDLE, CLEAR} clr_state_t;
  function automatic int unsigned byte_count(int unsigned data_width);
    return data_width / 8;
  endfunction
  function automatic logic [31:0] highest_onehot(logic [31:0] v);
    logic [31:0] h;
    h = '0;
    for (int i = 0; i < 32; i++) if (v[i]) h = 32'd1 << i;
    return h;
  endfunction
endpackage

// File: rtl/register_file_nr_nw_latch_clear_ctrl.sv
// register_file_clear_ctrl: sequences a word-by-word zero clear of the array
module register_file_clear_ctrl import register_file_latch_pkg::*; #(
  parameter int NUM_WORDS      = 32,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int ADDR_WIDTH     = $clog2(NUM_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  output logic                 busy_o,
  output logic [NUM_WORDS-1:0] clr_word
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_WORDS - 1);
  clr_state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  always_comb begin
    state_d = state_q == IDLE ? (clear_i ? CLEAR : IDLE) : (ptr_q == LAST ? IDLE : CLEAR);
    ptr_d   = state_q == CLEAR && ptr_q != LAST ? ptr_q + 1'b1 : '0;
    busy_o  = state_q == CLEAR;
    for (int w = 0; w < NUM_WORDS; w++) clr_word[w] = busy_o && ptr_q == ADDR_WIDTH'(w);
  end
endmodule

// File: rtl/tc_clk_gating.sv
// tc_clk_gating: latch-based glitch-free clock gate, enable captured while clk is low
module tc_clk_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);
  logic en_l;
  always_latch if (!clk_i) en_l = en_i | test_en_i;
  assign clk_o = clk_i & en_l;
endmodule

// File: rtl/register_file_nr_nw_latch.sv
// register_file_nr_nw_latch: multi-port latch register file with byte enables and clear engine
module register_file_nr_nw_latch import register_file_latch_pkg::*; #(
  parameter int NUM_WORDS      = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_RPORTS     = 2,
  parameter int NUM_WPORTS     = 2,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int ADDR_WIDTH     = $clog2(NUM_WORDS)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     clear_i,
  output logic                                     busy_o,
  input  logic [NUM_RPORTS-1:0]                    re_i,
  input  logic [NUM_RPORTS-1:0][ADDR_WIDTH-1:0]    raddr_i,
  output logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0]    rdata_o,
  input  logic [NUM_WPORTS-1:0]                    we_i,
  input  logic [NUM_WPORTS-1:0][ADDR_WIDTH-1:0]    waddr_i,
  input  logic [NUM_WPORTS-1:0][DATA_WIDTH-1:0]    wdata_i,
  input  logic [NUM_WPORTS-1:0][DATA_WIDTH/8-1:0]  wbe_i
);
  localparam int BYTES = byte_count(DATA_WIDTH);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [NUM_WORDS-1:0] clr_word;
  logic [NUM_WORDS-1:0][BYTES-1:0][NUM_WPORTS-1:0] hit, hot_q;
  logic [NUM_WORDS-1:0][BYTES-1:0] en;
  logic [NUM_WORDS-1:0][BYTES-1:0][7:0] din;
  logic [NUM_WPORTS-1:0][DATA_WIDTH-1:0] wdata_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [NUM_RPORTS-1:0][ADDR_WIDTH-1:0] raddr_q;
  logic clk_glob;

  register_file_clear_ctrl #(
    .NUM_WORDS     (NUM_WORDS),
    .CLEAR_ON_RESET(CLEAR_ON_RESET),
    .ADDR_WIDTH    (ADDR_WIDTH)
  ) i_clear_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear_i),
    .busy_o  (busy_o),
    .clr_word(clr_word)
  );

  always_comb
    for (int w = 0; w < NUM_WORDS; w++)
      for (int b = 0; b < BYTES; b++) begin
        for (int p = 0; p < NUM_WPORTS; p++)
          hit[w][b][p] = we_i[p] && !busy_o && wbe_i[p][b] && waddr_i[p] == ADDR_WIDTH'(w);
        en[w][b] = |hit[w][b] || clr_word[w];
      end

  tc_clk_gating i_cg_glob (
    .clk_i    (clk),
    .en_i     (|en),
    .test_en_i(1'b0),
    .clk_o    (clk_glob)
  );

  // an all-zero source selection drives zero into the lane, which is how the clear writes
  always_ff @(posedge clk_glob) begin
    wdata_q <= wdata_i;
    for (int w = 0; w < NUM_WORDS; w++)
      for (int b = 0; b < BYTES; b++)
        hot_q[w][b] <= NUM_WPORTS'(highest_onehot(32'(hit[w][b])));
  end

  always_comb
    for (int w = 0; w < NUM_WORDS; w++)
      for (int b = 0; b < BYTES; b++) begin
        din[w][b] = '0;
        for (int p = 0; p < NUM_WPORTS; p++)
          din[w][b] |= hot_q[w][b][p] ? wdata_q[p][8*b +: 8] : 8'h00;
      end

  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
    for (genvar b = 0; b < BYTES; b++) begin : g_byte
      logic gclk;
      logic [7:0] q;
      tc_clk_gating i_cg (
        .clk_i    (clk),
        .en_i     (en[w][b]),
        .test_en_i(1'b0),
        .clk_o    (gclk)
      );
      always_latch if (gclk) q = din[w][b];
      assign mem[w][8*b +: 8] = q;
    end
  end

  for (genvar w = NUM_WORDS; w < DEPTH; w++) begin : g_pad
    assign mem[w] = '0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) raddr_q <= '0;
    else for (int r = 0; r < NUM_RPORTS; r++) if (re_i[r]) raddr_q[r] <= raddr_i[r];

  always_comb for (int r = 0; r < NUM_RPORTS; r++) rdata_o[r] = mem[raddr_q[r]];
endmodule

// File: tb/tb_register_file_nr_nw_latch.sv
// tb_register_file_nr_nw_latch: directed and random checks against an array-level model
module tb_register_file_nr_nw_latch;
  localparam int NW = 12, DW = 32, NR = 2, NP = 2, AW = 4;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, busy;
  logic [NR-1:0] re;
  logic [NR-1:0][AW-1:0] raddr;
  logic [NR-1:0][DW-1:0] rdata;
  logic [NP-1:0] we;
  logic [NP-1:0][AW-1:0] waddr;
  logic [NP-1:0][DW-1:0] wdata;
  logic [NP-1:0][3:0] wbe;
  int errors = 0, checks = 0;
  logic [DW-1:0] mem_m [NW];
  logic [AW-1:0] raddr_m [NR];
  int remaining = 0;

  always #5 clk = ~clk;

  register_file_nr_nw_latch #(
    .NUM_WORDS(NW), .DATA_WIDTH(DW), .NUM_RPORTS(NR), .NUM_WPORTS(NP), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear), .busy_o(busy),
    .re_i(re), .raddr_i(raddr), .rdata_o(rdata),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wbe_i(wbe)
  );

  task automatic chk(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    we = '0; re = '0; clear = 1'b0;
  endtask

  task automatic wr(int p, int a, logic [DW-1:0] d, logic [3:0] be);
    we[p] = 1'b1; waddr[p] = AW'(a); wdata[p] = d; wbe[p] = be;
  endtask

  task automatic rd(int r, int a);
    re[r] = 1'b1; raddr[r] = AW'(a);
  endtask

  // one clock cycle: apply this cycle's inputs to the model, then compare mid next cycle
  task automatic tick(string tag);
    if (remaining > 0) begin
      mem_m[NW - remaining] = '0;
      remaining--;
    end else begin
      for (int p = 0; p < NP; p++)
        if (we[p] && int'(waddr[p]) < NW)
          for (int b = 0; b < 4; b++)
            if (wbe[p][b]) mem_m[waddr[p]][8*b +: 8] = wdata[p][8*b +: 8];
      if (clear) remaining = NW;
    end
    for (int r = 0; r < NR; r++) if (re[r]) raddr_m[r] = raddr[r];
    @(negedge clk);
    chk({tag, "_busy"}, 32'(busy), 32'(remaining > 0));
    for (int r = 0; r < NR; r++)
      chk($sformatf("%s_rd%0d", tag, r), rdata[r], int'(raddr_m[r]) < NW ? mem_m[raddr_m[r]] : '0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b1;
    remaining = NW;
    for (int r = 0; r < NR; r++) raddr_m[r] = '0;
  endtask

  task automatic read_all(string tag);
    for (int a = 0; a < NW; a++) begin
      idle(); rd(0, a); rd(1, NW - 1 - a);
      tick(tag);
    end
    idle();
  endtask

  initial begin
    idle(); raddr = '0; waddr = '0; wdata = '0; wbe = '0;
    for (int i = 0; i < NW; i++) mem_m[i] = '0;
    for (int r = 0; r < NR; r++) raddr_m[r] = '0;
    @(negedge clk);
    do_reset();
    repeat (NW) tick("init");
    chk("init_done", 32'(busy), 32'd0);
    read_all("init_scan");

    wr(0, 3, 32'hDEADBEEF, 4'hF); tick("wr3");
    idle(); rd(1, 3); tick("rd3");
    chk("deadbeef", rdata[1], 32'hDEADBEEF);

    idle(); wr(0, 5, 32'h11111111, 4'hF); wr(1, 5, 32'h22222222, 4'h3); tick("coll");
    idle(); rd(0, 5); tick("coll_rd");
    chk("collision", rdata[0], 32'h11112222);

    idle(); wr(0, 7, 32'hA5A5A5A5, 4'hF); rd(1, 7); tick("wt");
    chk("write_through", rdata[1], 32'hA5A5A5A5);

    idle(); clear = 1'b1; tick("clr_req");
    idle(); tick("clr1");
    wr(0, 3, 32'h12345678, 4'hF); wr(1, 9, 32'h87654321, 4'hF); clear = 1'b1; tick("clr2");
    idle(); repeat (NW - 2) tick("clr");
    chk("clr_done", 32'(busy), 32'd0);
    wr(0, 4, 32'hCAFEF00D, 4'hF); tick("post_clr");
    idle(); read_all("clr_scan");
    rd(0, 3); rd(1, 4); tick("clr_chk");
    chk("clr_drop", rdata[0], 32'h0);
    chk("post_clr_wr", rdata[1], 32'hCAFEF00D);

    idle(); wr(0, 12, 32'hFFFFFFFF, 4'hF); wr(1, 15, 32'hFFFFFFFF, 4'hF); rd(0, 12); tick("oor");
    chk("oor_rd", rdata[0], 32'h0);
    idle(); read_all("oor_scan");

    repeat (400) begin
      for (int p = 0; p < NP; p++) begin
        we[p] = 1'($urandom); waddr[p] = AW'($urandom_range(0, 13));
        wdata[p] = $urandom; wbe[p] = 4'($urandom);
      end
      for (int r = 0; r < NR; r++) begin
        re[r] = 1'($urandom); raddr[r] = AW'($urandom_range(0, 13));
      end
      clear = $urandom_range(0, 39) == 0;
      tick("rnd");
    end
    idle(); repeat (NW + 1) tick("drain");

    wr(0, 2, 32'h5A5A5A5A, 4'hF); clear = 1'b1; tick("mid_req");
    idle(); repeat (5) tick("mid");
    do_reset();
    repeat (NW) tick("rst_clr");
    chk("rst_clr_done", 32'(busy), 32'd0);
    read_all("rst_scan");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
